// File: rtl/vga_text_pipe_if.sv
//==============================================================================
// Module      : vga_text_pipe_if
// Description : Memory-side bus of the character pixel pipeline. It carries
//               the text RAM address/data and the font ROM address/data.
//               The master (the pipeline) drives both addresses. The slave
//               (the memories) returns data with a 1-cycle read latency.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface vga_text_pipe_if;
    logic [11:0] cram_addr;  // text RAM read address
    logic [15:0] cram_data;  // {bg[3:0], fg[3:0], code[7:0]}
    logic [11:0] font_addr;  // {code[7:0], glyph_row[3:0]}
    logic [7:0]  font_data;  // glyph row, bit 7 is the leftmost pixel

    modport master (
        output cram_addr,
        output font_addr,
        input  cram_data,
        input  font_data
    );

    modport slave (
        input  cram_addr,
        input  font_addr,
        output cram_data,
        output font_data
    );
endinterface

`default_nettype wire

// File: rtl/vga_text_pipe.sv
//==============================================================================
// Module      : vga_text_pipe
// Description : Character-mode pixel pipeline placed after the VGA timing
//               generator. It maps each pixel to a text cell and fetches the
//               cell from the text RAM. It then fetches the glyph row from the
//               font ROM and expands the IRGB colour code to 4-bit RGB.
//               Sync and blank travel through the same 3 stages, so all
//               vga_* outputs lag the inputs by exactly 3 clocks.
//               Optional feature macro: VGA_CURSOR_EN. When it is defined,
//               the block builds a blinking underline cursor on glyph rows
//               14-15 of the cursor cell.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module vga_text_pipe #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 30
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic [9:0]    row_i,
    input  wire logic [9:0]    col_i,
    input  wire logic          sync_h,
    input  wire logic          sync_v,
    input  wire logic          blank_n,
    vga_text_pipe_if.master    mem,
    input  wire logic [6:0]    cursor_x,
    input  wire logic [4:0]    cursor_y,
    output logic [3:0]         vga_r,
    output logic [3:0]         vga_g,
    output logic [3:0]         vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_blank_n
);

    // -------------------------------------------------------------------------
    // Cell mapping of the incoming pixel
    // -------------------------------------------------------------------------
    logic [6:0]  w_cell_x;
    logic [5:0]  w_cell_y;
    logic [3:0]  w_glyph_row;
    logic [2:0]  w_bit_idx;
    logic [11:0] w_cell_addr;

    assign w_cell_x    = col_i[9:3];
    assign w_cell_y    = row_i[9:4];
    assign w_glyph_row = row_i[3:0];
    assign w_bit_idx   = ~col_i[2:0];   // 7 - col[2:0]: bit 7 is the leftmost pixel

    // Linear cell address. Blanked pixels park the RAM on address 0 so the
    // retrace region never produces out-of-range reads.
    assign w_cell_addr   = 12'(32'(w_cell_y) * COLS + 32'(w_cell_x));
    assign mem.cram_addr = blank_n ? w_cell_addr : 12'd0;

    // -------------------------------------------------------------------------
    // Stage 1 registers (text RAM data is valid while these are held)
    // -------------------------------------------------------------------------
    logic [3:0] r_s1_glyph_row;
    logic [2:0] r_s1_bit_idx;
    logic       r_s1_hs;
    logic       r_s1_vs;
    logic       r_s1_blank_n;

    // Capture the pixel position and the timing flags alongside the RAM read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_glyph_row <= 4'd0;
            r_s1_bit_idx   <= 3'd0;
            r_s1_hs        <= 1'b1;
            r_s1_vs        <= 1'b1;
            r_s1_blank_n   <= 1'b0;
        end else begin
            r_s1_glyph_row <= w_glyph_row;
            r_s1_bit_idx   <= w_bit_idx;
            r_s1_hs        <= sync_h;
            r_s1_vs        <= sync_v;
            r_s1_blank_n   <= blank_n;
        end
    end

    // The glyph lookup uses the character code that just arrived from the RAM
    assign mem.font_addr = {mem.cram_data[7:0], r_s1_glyph_row};

    // -------------------------------------------------------------------------
    // Cursor overlay (optional)
    // -------------------------------------------------------------------------
    logic w_cursor_hit;

`ifdef VGA_CURSOR_EN
    localparam int                 c_CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(BLINK_FRAMES - 1);

    logic [6:0]         r_s1_cell_x;
    logic [5:0]         r_s1_cell_y;
    logic [6:0]         r_s1_cur_x;
    logic [4:0]         r_s1_cur_y;
    logic [c_CNT_W-1:0] r_blink_cnt;
    logic               r_blink_phase;
    logic               w_frame_tick;
    logic               w_cur_on_screen;

    // The cursor position is sampled together with the pixel. A move then
    // applies from the next pixel that enters stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_cell_x <= 7'd0;
            r_s1_cell_y <= 6'd0;
            r_s1_cur_x  <= 7'd0;
            r_s1_cur_y  <= 5'd0;
        end else begin
            r_s1_cell_x <= w_cell_x;
            r_s1_cell_y <= w_cell_y;
            r_s1_cur_x  <= cursor_x;
            r_s1_cur_y  <= cursor_y;
        end
    end

    // A frame starts when the input vsync falls. Detect this against the
    // stage-1 copy so that no extra delay register is needed.
    assign w_frame_tick = r_s1_vs & ~sync_v;

    // Count frames for each blink half-period. When the count wraps, flip
    // the phase on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_frame_tick) begin
            if (r_blink_cnt == c_CNT_MAX) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + 1'b1;
            end
        end
    end

    // A cursor parked outside the text area must never light up a cell that
    // happens to alias it in the overscan region
    assign w_cur_on_screen = (32'(r_s1_cur_x) < COLS) && (32'(r_s1_cur_y) < ROWS);

    assign w_cursor_hit = w_cur_on_screen
                        && (r_s1_cell_x == r_s1_cur_x)
                        && (r_s1_cell_y == {1'b0, r_s1_cur_y})
                        && (r_s1_glyph_row >= 4'd14)
                        && r_blink_phase;
`else
    logic        w_unused_cursor;
    logic [31:0] w_unused_params;

    // Cursor ports and parameters stay on the boundary but feed nothing
    assign w_unused_cursor = ^{cursor_x, cursor_y};
    assign w_unused_params = 32'(ROWS) ^ 32'(BLINK_FRAMES);
    assign w_cursor_hit    = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Stage 2 registers (font ROM data is valid while these are held)
    // -------------------------------------------------------------------------
    logic [3:0] r_s2_fg;
    logic [3:0] r_s2_bg;
    logic [2:0] r_s2_bit_idx;
    logic       r_s2_hit;
    logic       r_s2_hs;
    logic       r_s2_vs;
    logic       r_s2_blank_n;

    // Latch the cell colours and the cursor decision next to the font read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_fg      <= 4'd0;
            r_s2_bg      <= 4'd0;
            r_s2_bit_idx <= 3'd0;
            r_s2_hit     <= 1'b0;
            r_s2_hs      <= 1'b1;
            r_s2_vs      <= 1'b1;
            r_s2_blank_n <= 1'b0;
        end else begin
            r_s2_fg      <= mem.cram_data[11:8];
            r_s2_bg      <= mem.cram_data[15:12];
            r_s2_bit_idx <= r_s1_bit_idx;
            r_s2_hit     <= w_cursor_hit;
            r_s2_hs      <= r_s1_hs;
            r_s2_vs      <= r_s1_vs;
            r_s2_blank_n <= r_s1_blank_n;
        end
    end

    // -------------------------------------------------------------------------
    // Pixel selection and IRGB expansion
    // -------------------------------------------------------------------------
    logic       w_font_bit;
    logic [3:0] w_color;
    logic [3:0] w_r;
    logic [3:0] w_g;
    logic [3:0] w_b;

    assign w_font_bit = mem.font_data[r_s2_bit_idx];
    assign w_color    = (w_font_bit | r_s2_hit) ? r_s2_fg : r_s2_bg;

    // Each channel is the colour bit in the two upper bits, plus intensity
    // in the two lower bits
    assign w_r = {w_color[2], w_color[2], w_color[3], w_color[3]};
    assign w_g = {w_color[1], w_color[1], w_color[3], w_color[3]};
    assign w_b = {w_color[0], w_color[0], w_color[3], w_color[3]};

    // -------------------------------------------------------------------------
    // Stage 3: output register
    // -------------------------------------------------------------------------
    logic [3:0] r_s3_r;
    logic [3:0] r_s3_g;
    logic [3:0] r_s3_b;
    logic       r_s3_hs;
    logic       r_s3_vs;
    logic       r_s3_blank_n;

    // Register the final pixel and force black outside the visible area
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_r       <= 4'd0;
            r_s3_g       <= 4'd0;
            r_s3_b       <= 4'd0;
            r_s3_hs      <= 1'b1;
            r_s3_vs      <= 1'b1;
            r_s3_blank_n <= 1'b0;
        end else begin
            r_s3_r       <= r_s2_blank_n ? w_r : 4'd0;
            r_s3_g       <= r_s2_blank_n ? w_g : 4'd0;
            r_s3_b       <= r_s2_blank_n ? w_b : 4'd0;
            r_s3_hs      <= r_s2_hs;
            r_s3_vs      <= r_s2_vs;
            r_s3_blank_n <= r_s2_blank_n;
        end
    end

    assign vga_r       = r_s3_r;
    assign vga_g       = r_s3_g;
    assign vga_b       = r_s3_b;
    assign vga_hs      = r_s3_hs;
    assign vga_vs      = r_s3_vs;
    assign vga_blank_n = r_s3_blank_n;

endmodule

`default_nettype wire

// File: tb/tb_vga_text_pipe.sv
//==============================================================================
// Module      : tb_vga_text_pipe
// Description : Bench for vga_text_pipe. Directed scenarios plus randomized
//               pixel streams are compared against a behavioural reference
//               model. The model computes each output pixel directly from the
//               text RAM and font ROM contents and from a frame-tick count.
//               Honours VGA_CURSOR_EN in the same way as the design.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_vga_text_pipe;

    localparam int TB_COLS  = 80;
    localparam int TB_ROWS  = 30;
    localparam int TB_BLINK = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [9:0] row_i = '0;
    logic [9:0] col_i = '0;
    logic       sync_h = 1'b1;
    logic       sync_v = 1'b1;
    logic       blank_n = 1'b0;
    logic [6:0] cursor_x = 7'd3;
    logic [4:0] cursor_y = 5'd2;
    logic [3:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank_n;

    vga_text_pipe_if mem ();

    vga_text_pipe #(
        .COLS         (TB_COLS),
        .ROWS         (TB_ROWS),
        .BLINK_FRAMES (TB_BLINK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row_i       (row_i),
        .col_i       (col_i),
        .sync_h      (sync_h),
        .sync_v      (sync_v),
        .blank_n     (blank_n),
        .mem         (mem),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n)
    );

    always #5 clk = ~clk;

    // Synchronous memories with a 1-cycle read latency
    logic [15:0] text_ram [0:4095];
    logic [7:0]  font_rom [0:4095];

    always @(posedge clk) begin
        mem.cram_data <= text_ram[mem.cram_addr];
        mem.font_data <= font_rom[mem.font_addr];
    end

    int          checks   = 0;
    int          failures = 0;
    int          ticks    = 0;
    logic        prev_vs  = 1'b1;
    int          hs_run   = 0;
    int          hs_last_run = 0;
    logic [14:0] exp_q [$];

    localparam logic [14:0] RESET_OUT = 15'b000000000000_1_1_0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [14:0] obs();
        return {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n};
    endfunction

    // Reference: output pixel for one input pixel. The blink phase comes from
    // the number of vsync falls seen so far.
    function automatic logic [14:0] model(input int row, input int col, input logic hs,
                                          input logic vs, input logic bl, input int cx,
                                          input int cy, input int tick_cnt);
        int   addr, code, gl, c, rr, gg, bb;
        logic bitv, cur_match, hit;
        if (!bl) return {12'd0, hs, vs, 1'b0};
        addr = ((row / 16) * TB_COLS + col / 8) % 4096;
        code = int'(text_ram[addr][7:0]);
        gl   = int'(font_rom[code * 16 + row % 16]);
        bitv = ((gl >> (7 - col % 8)) & 1) == 1;
        cur_match = (col / 8 == cx) && (row / 16 == cy) && (cx < TB_COLS) && (cy < TB_ROWS)
                    && (row % 16 >= 14) && (((tick_cnt / TB_BLINK) % 2) == 1);
        hit = cur_match;
`ifndef VGA_CURSOR_EN
        hit = 1'b0;
`endif
        c  = (bitv || hit) ? int'(text_ram[addr][11:8]) : int'(text_ram[addr][15:12]);
        rr = ((c >> 2) & 1) * 12 + ((c >> 3) & 1) * 3;
        gg = ((c >> 1) & 1) * 12 + ((c >> 3) & 1) * 3;
        bb = (c & 1) * 12 + ((c >> 3) & 1) * 3;
        return {rr[3:0], gg[3:0], bb[3:0], hs, vs, 1'b1};
    endfunction

    // One pixel clock. Check the output due now, then drive the next input.
    task automatic step(input int row, input int col, input logic hs, input logic vs,
                        input logic bl);
        @(negedge clk);
        if (exp_q.size() >= 3) check_eq("pixel", 32'(obs()), 32'(exp_q.pop_front()));
        if (!vga_hs) hs_run++;
        else begin
            if (hs_run > 0) hs_last_run = hs_run;
            hs_run = 0;
        end
        row_i   = 10'(row);
        col_i   = 10'(col);
        sync_h  = hs;
        sync_v  = vs;
        blank_n = bl;
        if (prev_vs && !vs) ticks++;
        prev_vs = vs;
        exp_q.push_back(model(row, col, hs, vs, bl, int'(cursor_x), int'(cursor_y), ticks));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 700, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1 check_eq("rst_out", 32'(obs()), 32'(RESET_OUT));
        row_i = '0; col_i = '0; sync_h = 1'b1; sync_v = 1'b1; blank_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (3) exp_q.push_back(RESET_OUT);
        ticks   = 0;
        prev_vs = 1'b1;
        hs_run  = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int   row, col, sel;
        logic hs_cur, vs_cur, bl;
        logic [3:0] exp_r;

        for (int i = 0; i < 4096; i++) begin
            text_ram[i] = 16'($urandom);
            font_rom[i] = 8'($urandom);
        end
        text_ram[0]             = 16'h1A41;
        font_rom[12'h410]       = 8'h80;
        text_ram[2399]          = 16'h5C07;
        font_rom[12'h07F]       = 8'h01;
        font_rom[12'h07E]       = 8'h00;
        text_ram[2 * 80 + 3]    = 16'h2F00;
        text_ram[240]           = 16'h2F00;
        font_rom[12'h00E]       = 8'h00;
        font_rom[12'h00F]       = 8'h00;

        // Reset values and the first visible pixel
        apply_reset();
        step(0, 0, 1'b1, 1'b1, 1'b1);
        #1 check_eq("cram_addr_0", 32'(mem.cram_addr), 32'd0);
        @(posedge clk);
        #1 check_eq("font_addr_410", 32'(mem.font_addr), 32'h410);
        idle(3);
        check_eq("fg_A_rgb", 32'({vga_r, vga_g, vga_b}), 32'h3F3);

        // Blanked pixel parks the RAM address and outputs black
        step(300, 641, 1'b1, 1'b1, 1'b0);
        #1 check_eq("cram_addr_blank", 32'(mem.cram_addr), 32'd0);
        idle(3);
        check_eq("blank_out", 32'({vga_r, vga_g, vga_b, vga_blank_n}), 32'd0);

        // Last visible cell, glyph rows 15 (bit0=1 -> fg) and 14 (bit0=0 -> bg)
        step(479, 639, 1'b1, 1'b1, 1'b1);
        #1 check_eq("cram_addr_max", 32'(mem.cram_addr), 32'd2399);
        @(posedge clk);
        #1 check_eq("font_row_F", 32'(mem.font_addr[3:0]), 32'hF);
        step(478, 639, 1'b1, 1'b1, 1'b1);
        idle(2);
        check_eq("bit0_fg", 32'({vga_r, vga_g, vga_b}), 32'hF33);
        idle(1);
        check_eq("bit0_bg", 32'({vga_r, vga_g, vga_b}), 32'hC0C);

        // Horizontal sync pulse width through the pipeline
        idle(4);
        hs_last_run = 0;
        for (int i = 0; i < 96; i++) step(5, i, 1'b0, 1'b1, 1'b0);
        idle(8);
        check_eq("hs_width", 32'(hs_last_run), 32'd96);

        // Cursor blink with BLINK_FRAMES=2 at cell (3,2), rows 14-15
        apply_reset();
        cursor_x = 7'd3;
        cursor_y = 5'd2;
        idle(2);
        for (int f = 1; f <= 8; f++) begin
            step(0, 700, 1'b1, 1'b0, 1'b0);
            step(0, 700, 1'b1, 1'b1, 1'b0);
            for (int c = 24; c < 32; c++) step(46, c, 1'b1, 1'b1, 1'b1);
            step(47, 27, 1'b1, 1'b1, 1'b1);
            idle(3);
            exp_r = 4'h0;
`ifdef VGA_CURSOR_EN
            if (f % 4 >= 2) exp_r = 4'hF;
`endif
            check_eq("cursor_blink", 32'(vga_r), 32'(exp_r));
        end

        // Off-screen cursor column never shows, even in the aliased cell
        idle(2);
        cursor_x = 7'd80;
        for (int f = 0; f < 2; f++) begin
            step(0, 700, 1'b1, 1'b0, 1'b0);
            step(0, 700, 1'b1, 1'b1, 1'b0);
        end
        step(46, 643, 1'b1, 1'b1, 1'b1);
        idle(3);
        check_eq("cursor_offscreen", 32'(vga_r), 32'd0);

        // Randomized pixel stream with moving cursor and random syncs
        hs_cur = 1'b1;
        vs_cur = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) begin
                step(0, 700, hs_cur, vs_cur, 1'b0);
                step(0, 700, hs_cur, vs_cur, 1'b0);
                cursor_x = 7'($urandom_range(0, 90));
                cursor_y = 5'($urandom_range(0, 31));
            end
            if ($urandom_range(0, 19) == 0) hs_cur = ~hs_cur;
            if ($urandom_range(0, 14) == 0) vs_cur = ~vs_cur;
            bl  = ($urandom_range(0, 3) != 0);
            sel = int'($urandom_range(0, 9));
            if (sel < 3) begin
                row = int'(cursor_y) * 16 + int'($urandom_range(12, 15));
                col = int'(cursor_x) * 8 + int'($urandom_range(0, 7));
            end else if (sel == 3) begin
                row = int'($urandom_range(0, 1023));
                col = int'($urandom_range(0, 1023));
            end else begin
                row = int'($urandom_range(0, 479));
                col = int'($urandom_range(0, 639));
            end
            step(row, col, hs_cur, vs_cur, bl);
        end

        // Asynchronous reset in the middle of an hsync pulse
        for (int i = 0; i < 20; i++) step(100, 200 + i, 1'b0, 1'b1, 1'b1);
        check_eq("pre_rst_hs", 32'(vga_hs), 32'd0);
        apply_reset();
        step(10, 10, 1'b1, 1'b1, 1'b1);
        idle(2);
        check_eq("realign_early", 32'(vga_blank_n), 32'd0);
        idle(1);
        check_eq("realign_blank", 32'(vga_blank_n), 32'd1);
        for (int i = 0; i < 50; i++)
            step(int'($urandom_range(0, 479)), int'($urandom_range(0, 639)), 1'b1, 1'b1, 1'b1);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
